// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: boot-time loader sequencing, fetch/loader arbitration
// with loader anti-starvation, registered fetch data and bad-address flagging.
module imem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 127,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              boot_start_i,
  input  logic              boot_done_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_gnt_o,
  output logic              fetch_valid_o,
  output logic [DATA_W-1:0] fetch_data_o,
  output logic              fetch_err_o,
  input  logic              load_req_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_gnt_o,
  output logic              load_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              booting_o,
  output logic              dbg_state,
  output logic [CNT_W-1:0]  dbg_starve_cnt
);

  localparam logic ST_BOOT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic             state;
  logic [CNT_W-1:0] starve_cnt;
  logic             fetch_bad;
  logic             load_bad;

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] idx;
    idx = a >> 2;
    return (a[1:0] != 2'b00) || (idx >= DEPTH_W);
  endfunction

  assign fetch_bad = addr_bad(fetch_addr_i);
  assign load_bad  = addr_bad(load_addr_i);

  // Handshake: a transfer happens in any cycle where req && gnt; a requester keeps
  // addr/data stable while req is high and gnt is low. Grants are combinational.
  always_comb begin
    fetch_gnt_o = 1'b0;
    load_gnt_o  = 1'b0;
    if (!rst_i) begin
      fetch_gnt_o = 1'b0;
      load_gnt_o  = 1'b0;
    end else if (state == ST_BOOT) begin
      load_gnt_o = load_req_i;
    end else if (fetch_req_i && load_req_i) begin
      if (starve_cnt == LIMIT_C) load_gnt_o  = 1'b1;
      else                       fetch_gnt_o = 1'b1;
    end else begin
      fetch_gnt_o = fetch_req_i;
      load_gnt_o  = load_req_i;
    end
  end

  always_comb begin
    mem_wdata_o = load_data_i;
    if (load_gnt_o) begin
      mem_addr_o = load_addr_i >> 2;
      mem_we_o   = !load_bad;
    end else begin
      mem_addr_o = fetch_addr_i >> 2;
      mem_we_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= ST_BOOT;
      starve_cnt    <= '0;
      fetch_valid_o <= 1'b0;
      fetch_data_o  <= '0;
      fetch_err_o   <= 1'b0;
      load_err_o    <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: if (boot_done_i)  state <= ST_RUN;
        default: if (boot_start_i) state <= ST_BOOT;
      endcase

      // Counts consecutive cycles the loader waited and lost; saturates at the limit.
      if (load_gnt_o || !load_req_i) starve_cnt <= '0;
      else if (starve_cnt != LIMIT_C) starve_cnt <= starve_cnt + 1'b1;

      fetch_valid_o <= fetch_gnt_o;
      fetch_err_o   <= fetch_gnt_o && fetch_bad;
      if (fetch_gnt_o) fetch_data_o <= fetch_bad ? '0 : mem_rdata_i;
      load_err_o    <= load_gnt_o && load_bad;
    end
  end

  assign booting_o      = (state == ST_BOOT);
  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model with its own shadow memory.
module tb_imem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 127;
  localparam int LIMIT = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          boot_start_i = 1'b0, boot_done_i = 1'b0;
  logic          fetch_req_i = 1'b0, load_req_i = 1'b0;
  logic [AW-1:0] fetch_addr_i = '0, load_addr_i = '0;
  logic [DW-1:0] load_data_i = '0;
  logic          fetch_gnt_o, fetch_valid_o, fetch_err_o, load_gnt_o, load_err_o;
  logic [DW-1:0] fetch_data_o, mem_wdata_o, mem_rdata_i;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o, booting_o, dbg_state;
  logic [2:0]    dbg_starve_cnt;

  imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .boot_start_i(boot_start_i), .boot_done_i(boot_done_i),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_gnt_o(fetch_gnt_o),
    .fetch_valid_o(fetch_valid_o), .fetch_data_o(fetch_data_o), .fetch_err_o(fetch_err_o),
    .load_req_i(load_req_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
    .load_gnt_o(load_gnt_o), .load_err_o(load_err_o), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .booting_o(booting_o), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock / memory array
  always #5 clk_i = ~clk_i;

  logic [DW-1:0] mem [DEPTH];
  assign mem_rdata_i = (mem_addr_o < AW'(DEPTH)) ? mem[mem_addr_o] : '0;
  always @(posedge clk_i) if (mem_we_o && mem_addr_o < AW'(DEPTH)) mem[mem_addr_o] <= mem_wdata_o;

  // reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_booting;
  int            m_losses;
  bit            m_exp_valid, m_exp_lerr;
  logic [DW-1:0] m_last_data;
  logic [DW:0]   exp_q[$];   // {err, data}
  bit            last_fg, last_lg;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bad_addr(input logic [AW-1:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  task automatic model_reset();
    m_booting   = 1;
    m_losses    = 0;
    m_exp_valid = 0;
    m_exp_lerr  = 0;
    m_last_data = '0;
    exp_q.delete();
    last_fg = 0;
    last_lg = 0;
  endtask

  // One cycle: check at the negedge, then advance the model to the next edge.
  task automatic step(input bit kill = 0);
    bit fg, lg, fbad, lbad;
    logic [DW:0] e;
    @(negedge clk_i);
    fbad = bad_addr(fetch_addr_i);
    lbad = bad_addr(load_addr_i);
    fg = 0; lg = 0;
    if (m_booting) lg = load_req_i;
    else if (fetch_req_i && load_req_i) begin
      if (m_losses == LIMIT) lg = 1; else fg = 1;
    end else begin
      fg = fetch_req_i; lg = load_req_i;
    end
    check("fetch_gnt", fetch_gnt_o, fg);
    check("load_gnt", load_gnt_o, lg);
    check("booting", booting_o, m_booting);
    check("mem_we", mem_we_o, lg && !lbad);
    check("mem_addr", mem_addr_o, lg ? load_addr_i / 4 : fetch_addr_i / 4);
    if (lg && !lbad) check("mem_wdata", mem_wdata_o, load_data_i);
    check("fetch_valid", fetch_valid_o, m_exp_valid);
    if (m_exp_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("fetch_data", fetch_data_o, e[DW-1:0]);
      check("fetch_err", fetch_err_o, e[DW]);
      m_last_data = e[DW-1:0];
    end else begin
      check("fetch_hold", fetch_data_o, m_last_data);
      check("fetch_err_idle", fetch_err_o, 1'b0);
    end
    check("load_err", load_err_o, m_exp_lerr);
    if (kill) begin
      rst_i = 1'b0;
      model_reset();
    end else begin
      m_exp_valid = fg;
      if (fg) exp_q.push_back(fbad ? {1'b1, {DW{1'b0}}} : {1'b0, ref_mem[fetch_addr_i / 4]});
      m_exp_lerr = lg && lbad;
      if (lg && !lbad) ref_mem[load_addr_i / 4] = load_data_i;
      if (lg || !load_req_i) m_losses = 0;
      else if (m_losses < LIMIT) m_losses++;
      if (m_booting) begin
        if (boot_done_i) m_booting = 0;
      end else if (boot_start_i) m_booting = 1;
      last_fg = fg;
      last_lg = lg;
    end
    @(posedge clk_i);
    #1;
  endtask

  // Holds reset (already asserted or asserted here) and checks reset values.
  task automatic apply_reset();
    rst_i = 1'b0;
    fetch_req_i = 0; load_req_i = 0; boot_start_i = 0; boot_done_i = 0;
    model_reset();
    @(negedge clk_i);
    check("rst_valid", fetch_valid_o, 1'b0);
    check("rst_data", fetch_data_o, '0);
    check("rst_ferr", fetch_err_o, 1'b0);
    check("rst_lerr", load_err_o, 1'b0);
    check("rst_booting", booting_o, 1'b1);
    check("rst_gnt", {fetch_gnt_o, load_gnt_o, mem_we_o}, 3'b000);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_fetch(input logic [AW-1:0] a);
    fetch_req_i = 1; fetch_addr_i = a; load_req_i = 0;
    step();
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_req_i = 1; load_addr_i = a; load_data_i = d; fetch_req_i = 0;
    step();
  endtask

  task automatic idle();
    fetch_req_i = 0; load_req_i = 0; boot_start_i = 0; boot_done_i = 0;
    step();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return AW'($urandom_range(0, 508)) | AW'($urandom_range(1, 3));
    if (r == 1) return AW'(DEPTH * 4);
    if (r == 2) return $urandom;
    if (r < 6) return AW'($urandom_range(0, DEPTH - 1) * 4);
    return AW'($urandom_range(0, 15) * 4);
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DW'(i) * 32'h01010101;
      ref_mem[i] = mem[i];
    end
    #12;
    apply_reset();

    // boot load then back-to-back fetch
    do_load(32'h0, 32'h8C010004);
    do_load(32'h4, 32'h00000020);
    load_req_i = 0; boot_done_i = 1; step(); boot_done_i = 0;
    do_fetch(32'h0);
    do_fetch(32'h4);
    idle();
    idle();

    // fetch blocked during boot, granted once RUN is entered
    apply_reset();
    do_fetch(32'h4);
    do_fetch(32'h4);
    boot_done_i = 1; step(); boot_done_i = 0;
    step();
    idle();

    // loader starvation breaker
    fetch_req_i = 1; fetch_addr_i = 32'h8;
    load_req_i = 1; load_addr_i = 32'h20; load_data_i = 32'hA5A5_0001;
    for (int i = 0; i < 5; i++) step();
    load_req_i = 0;
    step();
    step();
    idle();

    // bad addresses
    do_fetch(32'h2);
    do_fetch(32'h1FC);
    do_load(32'h1FC, 32'h1234_5678);
    do_fetch(32'h1F8);
    idle();

    // write-before-read on consecutive cycles
    do_load(32'h10, 32'hDEADBEEF);
    do_fetch(32'h10);
    idle();
    idle();

    // reset right after a fetch grant cancels the pending valid
    fetch_req_i = 1; fetch_addr_i = 32'h10;
    step(1'b1);
    apply_reset();
    boot_done_i = 1; step(); boot_done_i = 0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (!(fetch_req_i && !last_fg)) fetch_addr_i = rand_addr();
      if (!(load_req_i && !last_lg)) begin
        load_addr_i = rand_addr();
        load_data_i = $urandom;
      end
      fetch_req_i  = ($urandom_range(0, 3) != 0);
      if (load_req_i && !last_lg) load_req_i = 1;
      else load_req_i = ($urandom_range(0, 2) == 0);
      boot_start_i = ($urandom_range(0, 60) == 0);
      boot_done_i  = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 400) == 0) begin
        step(1'b1);
        apply_reset();
      end else step();
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
